ccu_mplier_seq: RTL and testbench



---
 rtl/ccu_mplier_seq_if.sv | 25 ++
 rtl/ccu_mplier_seq.sv | 147 ++++++++++++++
 tb/tb_ccu_mplier_seq.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccu_mplier_seq_if.sv
// Signal bundle between the multiplier digit sequencer and its environment
// (order decode, serial multiplier source, multiplicand-gating unit).
interface ccu_mplier_seq_if;
    logic       ev_d0;
    logic       mult_start;
    logic       mplier_in;
    logic       dx;
    logic       dx_m;
    logic       dy;
    logic       sub_m;
    logic       busy;
    logic       mult_done;
    logic [5:0] mdigit;

    // The sequencer is the initiating end towards the multiplicand gate.
    modport master (
        input  ev_d0, mult_start, mplier_in,
        output dx, dx_m, dy, sub_m, busy, mult_done, mdigit
    );

    modport slave (
        output ev_d0, mult_start, mplier_in,
        input  dx, dx_m, dy, sub_m, busy, mult_done, mdigit
    );
endinterface

// File: rtl/ccu_mplier_seq.sv
// Multiplier digit sequencer: captures the serial multiplier, then tests one digit per minor cycle.
// Optional sign-digit correction (sub_m) is enabled by defining CCU_MPLIER_SIGN_CORRECT_EN.
module ccu_mplier_seq #(
    parameter int unsigned WORD_BITS   = 35,
    parameter int unsigned MINOR_CYCLE = 36
) (
    input  logic             clk,
    input  logic             rst,
    ccu_mplier_seq_if.master bus
);

    localparam int unsigned   CW         = (MINOR_CYCLE > 2) ? $clog2(MINOR_CYCLE) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(MINOR_CYCLE - 1);
    localparam logic [CW-1:0] LAST_LOAD  = CW'(WORD_BITS - 1);
    localparam logic [5:0]    SIGN_DIGIT = 6'(WORD_BITS - 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ARM  = 3'd1;
    localparam logic [2:0] LOAD = 3'd2;
    localparam logic [2:0] TEST = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    if (WORD_BITS < 2 || WORD_BITS > MINOR_CYCLE || WORD_BITS > 64) begin : g_bad_params
        $error("ccu_mplier_seq: WORD_BITS must satisfy 2 <= WORD_BITS <= MINOR_CYCLE");
    end

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d, digit;
    logic [WORD_BITS-1:0] mreg_q, mreg_d;
    logic [5:0]           mdigit_q, mdigit_d;
    logic                 dx_q, dx_d;
    logic                 dy_q, dy_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 tested_q, tested_d;
    logic                 sign_sel;

    // Digit of the current clock; ev_d0 always resynchronises the count.
    always_comb begin
        digit = bus.ev_d0 ? '0 : cnt_q;
        cnt_d = (digit == LAST_DIGIT) ? LAST_DIGIT : digit + CW'(1);
    end

    always_comb begin
        state_d  = state_q;
        mreg_d   = mreg_q;
        mdigit_d = mdigit_q;
        tested_d = tested_q;
        dx_d     = 1'b0;
        dy_d     = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.mult_start) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                // Digit 0 of the new minor cycle arrives with ev_d0 itself.
                if (bus.ev_d0) begin
                    state_d  = LOAD;
                    mreg_d   = {bus.mplier_in, mreg_q[WORD_BITS-1:1]};
                    mdigit_d = '0;
                end
            end
            LOAD: begin
                if (bus.ev_d0) begin
                    state_d  = TEST;
                    dx_d     = 1'b1;
                    tested_d = 1'b1;
                end else if (digit <= LAST_LOAD) begin
                    mreg_d = {bus.mplier_in, mreg_q[WORD_BITS-1:1]};
                end
            end
            TEST: begin
                // An early ev_d0 re-tests the same digit; dy only follows a dx that
                // completed its full minor cycle, so dx_m/dy stay paired.
                if (bus.ev_d0) begin
                    dx_d     = 1'b1;
                    tested_d = 1'b1;
                end else if (digit == LAST_DIGIT && tested_q) begin
                    dy_d     = 1'b1;
                    tested_d = 1'b0;
                    mreg_d   = mreg_q >> 1;
                    mdigit_d = mdigit_q + 6'd1;
                    if (mdigit_q == SIGN_DIGIT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done_d   = 1'b1;
                mdigit_d = '0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE) || (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mreg_q   <= '0;
            mdigit_q <= '0;
            tested_q <= 1'b0;
            dx_q     <= 1'b0;
            dy_q     <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mreg_q   <= mreg_d;
            mdigit_q <= mdigit_d;
            tested_q <= tested_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

`ifdef CCU_MPLIER_SIGN_CORRECT_EN
    // The sign digit carries negative weight: subtract the multiplicand instead of adding it.
    assign sign_sel  = (mdigit_q == SIGN_DIGIT);
    assign bus.sub_m = dx_q & mreg_q[0] & sign_sel;
`else
    assign sign_sel  = 1'b0;
    assign bus.sub_m = 1'b0;
`endif

    assign bus.dx        = dx_q;
    assign bus.dx_m      = dx_q & mreg_q[0] & ~sign_sel;
    assign bus.dy        = dy_q;
    assign bus.busy      = busy_q;
    assign bus.mult_done = done_q;
    assign bus.mdigit    = mdigit_q;

    a_dxm_dy_exclusive: assert property (@(posedge clk) disable iff (rst) !(bus.dx_m && bus.dy));

endmodule

// File: tb/tb_ccu_mplier_seq.sv
// Directed bench for ccu_mplier_seq at default parameters; ev_d0 generated every 36 clocks.
module tb_ccu_mplier_seq;

    localparam int W  = 35;
    localparam int MC = 36;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ccu_mplier_seq_if bus ();

    ccu_mplier_seq #(
        .WORD_BITS  (W),
        .MINOR_CYCLE(MC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    int          edge_n = 0;
    int          phase = 0;
    logic [34:0] mword;
    int          n_dx, n_dy, n_dxm, n_sub, n_done, n_overlap;
    logic [34:0] dxm_mask, sub_mask;
    int          t0, start_edge, done_edge, first_dx, first_dy;
    bit          pending = 0;
    bit          track_start = 0;

    task automatic apply_inputs();
        bus.ev_d0     = (phase == 0);
        bus.mplier_in = (phase < W) ? mword[phase] : 1'b1;
    endtask

    task automatic clear_stats();
        n_dx = 0; n_dy = 0; n_dxm = 0; n_sub = 0; n_done = 0; n_overlap = 0;
        dxm_mask = '0; sub_mask = '0;
        t0 = -1; start_edge = -1; done_edge = -1; first_dx = -1; first_dy = -1;
        pending = 0; track_start = 0;
    endtask

    // Advance one clock, record what the DUT did, then present the next inputs.
    task automatic tick();
        @(posedge clk);
        edge_n++;
        if (bus.ev_d0 && pending) begin
            t0 = edge_n;
            pending = 0;
        end
        if (bus.mult_start && track_start) begin
            pending = 1;
            start_edge = edge_n;
            track_start = 0;
        end
        #1;
        if (bus.dx) begin
            n_dx++;
            if (first_dx < 0) first_dx = edge_n;
        end
        if (bus.dy) begin
            n_dy++;
            if (first_dy < 0) first_dy = edge_n;
        end
        if (bus.dx_m) begin
            n_dxm++;
            if (bus.mdigit < 35) dxm_mask[bus.mdigit] = 1'b1;
        end
        if (bus.sub_m) begin
            n_sub++;
            if (bus.mdigit < 35) sub_mask[bus.mdigit] = 1'b1;
        end
        if (bus.mult_done) begin
            n_done++;
            done_edge = edge_n;
        end
        if (bus.dx_m && bus.dy) n_overlap++;
        phase = (phase == MC - 1) ? 0 : phase + 1;
        apply_inputs();
    endtask

    // Issue mult_start on a clock well away from ev_d0.
    task automatic start_mult();
        int n = 0;
        while (phase != 10 && n < 2 * MC) begin
            tick();
            n++;
        end
        track_start = 1;
        bus.mult_start = 1'b1;
        tick();
        bus.mult_start = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while (n_done == 0 && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_dx_digit(input int d, input int budget);
        int n = 0;
        while (!(bus.dx === 1'b1 && bus.mdigit == 6'(d)) && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.dx, bus.dx_m, bus.dy, bus.sub_m, bus.busy, bus.mult_done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 000000",
                     {bus.dx, bus.dx_m, bus.dy, bus.sub_m, bus.busy, bus.mult_done});
        end
        checks++;
        if (bus.mdigit !== 6'd0) begin
            errors++;
            $display("FAIL reset_mdigit got %0d want 0", bus.mdigit);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        clear_stats();
        mword = 35'd5;
        start_mult();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_rise got %b want 1", bus.busy);
        end
        run_until_done(1500);
        checks++;
        if (n_done !== 1) begin errors++; $display("FAIL basic_done got %0d want 1", n_done); end
        checks++;
        if (done_edge - t0 !== 1296) begin
            errors++;
            $display("FAIL basic_done_time got %0d want 1296", done_edge - t0);
        end
        checks++;
        if (first_dx - t0 !== 36) begin
            errors++;
            $display("FAIL basic_first_dx got %0d want 36", first_dx - t0);
        end
        checks++;
        if (first_dy - t0 !== 71) begin
            errors++;
            $display("FAIL basic_first_dy got %0d want 71", first_dy - t0);
        end
        checks++;
        if (n_dx !== 35 || n_dy !== 35) begin
            errors++;
            $display("FAIL basic_pulses got dx=%0d dy=%0d want 35/35", n_dx, n_dy);
        end
        checks++;
        if (dxm_mask !== 35'd5 || n_dxm !== 2) begin
            errors++;
            $display("FAIL basic_dxm got mask=%h n=%0d want 5/2", dxm_mask, n_dxm);
        end
        checks++;
        if (n_sub !== 0 || n_overlap !== 0) begin
            errors++;
            $display("FAIL basic_sub_overlap got sub=%0d ovl=%0d want 0/0", n_sub, n_overlap);
        end
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_at_done got %b want 1", bus.busy);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.mult_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_after_done got busy=%b done=%b want 0/0", bus.busy, bus.mult_done);
        end
    endtask

    task automatic test_all_ones();
        clear_stats();
        mword = '1;
        start_mult();
        run_until_done(1500);
        checks++;
        if (n_done !== 1) begin errors++; $display("FAIL ones_done got %0d want 1", n_done); end
`ifdef CCU_MPLIER_SIGN_CORRECT_EN
        checks++;
        if (n_dxm !== 34 || dxm_mask !== 35'h3_FFFF_FFFF) begin
            errors++;
            $display("FAIL ones_dxm got n=%0d mask=%h want 34/3ffffffff", n_dxm, dxm_mask);
        end
        checks++;
        if (n_sub !== 1 || sub_mask !== 35'h4_0000_0000) begin
            errors++;
            $display("FAIL ones_sub got n=%0d mask=%h want 1/400000000", n_sub, sub_mask);
        end
`else
        checks++;
        if (n_dxm !== 35 || dxm_mask !== 35'h7_FFFF_FFFF) begin
            errors++;
            $display("FAIL ones_dxm got n=%0d mask=%h want 35/7ffffffff", n_dxm, dxm_mask);
        end
        checks++;
        if (n_sub !== 0) begin errors++; $display("FAIL ones_sub got %0d want 0", n_sub); end
`endif
        checks++;
        if (n_overlap !== 0) begin
            errors++;
            $display("FAIL ones_overlap got %0d want 0", n_overlap);
        end
    endtask

    task automatic test_coincident();
        logic [34:0] wb;
        int n = 0;
        wb = 35'h5_A5C3_0F96;
        clear_stats();
        mword = '1;
        while (bus.ev_d0 !== 1'b1 && n < 2 * MC) begin
            tick();
            n++;
        end
        track_start = 1;
        bus.mult_start = 1'b1;
        tick();
        bus.mult_start = 1'b0;
        n = 0;
        while (phase != 0 && n < 2 * MC) begin
            tick();
            n++;
        end
        // Minor cycle that actually loads carries a different word.
        mword = wb;
        apply_inputs();
        run_until_done(1500);
        checks++;
        if (t0 - start_edge !== 36) begin
            errors++;
            $display("FAIL coinc_load_delay got %0d want 36", t0 - start_edge);
        end
        checks++;
        if (dxm_mask !== wb || n_dxm !== $countones(wb)) begin
            errors++;
            $display("FAIL coinc_word got %h want %h", dxm_mask, wb);
        end
        checks++;
        if (n_done !== 1 || done_edge - t0 !== 1296) begin
            errors++;
            $display("FAIL coinc_done got n=%0d t=%0d want 1/1296", n_done, done_edge - t0);
        end
    endtask

    task automatic test_abort();
        clear_stats();
        mword = 35'h7FF;
        start_mult();
        wait_dx_digit(10, 1500);
        checks++;
        if (bus.dx !== 1'b1 || bus.mdigit !== 6'd10) begin
            errors++;
            $display("FAIL abort_reach got dx=%b md=%0d want 1/10", bus.dx, bus.mdigit);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({bus.dx, bus.dx_m, bus.dy, bus.sub_m, bus.busy, bus.mult_done, bus.mdigit} !== 12'b0)
        begin
            errors++;
            $display("FAIL abort_outputs got %b want 0",
                     {bus.dx, bus.dx_m, bus.dy, bus.sub_m, bus.busy, bus.mult_done, bus.mdigit});
        end
        rst = 1'b0;
        clear_stats();
        repeat (100) tick();
        checks++;
        if (n_dx !== 0 || n_dy !== 0 || n_done !== 0) begin
            errors++;
            $display("FAIL abort_quiet got dx=%0d dy=%0d done=%0d want 0/0/0", n_dx, n_dy, n_done);
        end
        clear_stats();
        mword = 35'd5;
        start_mult();
        run_until_done(1500);
        checks++;
        if (n_done !== 1 || done_edge - t0 !== 1296 || dxm_mask !== 35'd5) begin
            errors++;
            $display("FAIL abort_restart got n=%0d t=%0d mask=%h want 1/1296/5",
                     n_done, done_edge - t0, dxm_mask);
        end
    endtask

    task automatic test_double_start();
        clear_stats();
        mword = 35'h1F;
        start_mult();
        wait_dx_digit(5, 1500);
        bus.mult_start = 1'b1;
        tick();
        bus.mult_start = 1'b0;
        run_until_done(1500);
        repeat (100) tick();
        checks++;
        if (n_done !== 1 || done_edge - t0 !== 1296) begin
            errors++;
            $display("FAIL double_done got n=%0d t=%0d want 1/1296", n_done, done_edge - t0);
        end
        checks++;
        if (dxm_mask !== 35'h1F || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL double_state got mask=%h busy=%b want 1f/0", dxm_mask, bus.busy);
        end
    endtask

    task automatic test_early();
        clear_stats();
        mword = 35'h9;
        start_mult();
        wait_dx_digit(3, 1500);
        checks++;
        if (bus.dx_m !== 1'b1 || n_dy !== 3) begin
            errors++;
            $display("FAIL early_reach got dxm=%b dy=%0d want 1/3", bus.dx_m, n_dy);
        end
        repeat (19) tick();
        phase = 0;
        apply_inputs();
        tick();
        checks++;
        if (bus.dx !== 1'b1 || bus.dx_m !== 1'b1 || bus.mdigit !== 6'd3 || n_dy !== 3) begin
            errors++;
            $display("FAIL early_retest got dx=%b dxm=%b md=%0d dy=%0d want 1/1/3/3",
                     bus.dx, bus.dx_m, bus.mdigit, n_dy);
        end
        run_until_done(1500);
        checks++;
        if (n_dx !== 36 || n_dy !== 35 || n_dxm !== 3) begin
            errors++;
            $display("FAIL early_counts got dx=%0d dy=%0d dxm=%0d want 36/35/3", n_dx, n_dy, n_dxm);
        end
        checks++;
        if (n_done !== 1 || done_edge - t0 !== 1316 || n_overlap !== 0) begin
            errors++;
            $display("FAIL early_done got n=%0d t=%0d ovl=%0d want 1/1316/0",
                     n_done, done_edge - t0, n_overlap);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.mult_start = 1'b0;
        mword = '0;
        clear_stats();
        apply_inputs();
        test_reset();
        test_basic();
        test_all_ones();
        test_coincident();
        test_abort();
        test_double_start();
        test_early();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
